// File: rtl/packet_len_csum_buffer_if.sv
// AXI-stream bundle shared by the input and output sides of the packet buffer.
// A beat transfers on a rising edge where tvalid && tready; while tvalid=1 and tready=0 the source holds every payload field stable.
interface packet_len_csum_buffer_if #(
   parameter int DATA_W = 64,
   parameter int ID_W   = 4,
   parameter int DEST_W = 4
);
   logic [DATA_W-1:0]   tdata;
   logic [ID_W-1:0]     tid;
   logic [DEST_W-1:0]   tdest;
   logic [DATA_W/8-1:0] tkeep;
   logic                tlast;
   logic                tvalid;
   logic                tready;

   modport master (output tdata, tid, tdest, tkeep, tlast, tvalid, input tready);
   modport slave  (input tdata, tid, tdest, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/packet_len_csum_buffer.sv
// Store-and-forward packet buffer: measures byte length and ones-complement checksum per packet,
// drops oversize packets, and releases each packet only after its descriptor is committed.
module packet_len_csum_buffer #(
   parameter int AXIS_BUS_WIDTH    = 64,
   parameter int AXIS_ID_WIDTH     = 4,
   parameter int AXIS_DEST_WIDTH   = 4,
   parameter int MAX_PACKET_LENGTH = 1522,
   parameter int BUFFER_DEPTH      = 256,
   parameter int META_DEPTH        = 8,
   parameter int CALC_CHECKSUM     = 1
) (
   input  logic                            aclk,
   input  logic                            aresetn,
   packet_len_csum_buffer_if.slave         axis_in,
   packet_len_csum_buffer_if.master        axis_out,
   output logic [15:0]                     out_length,
   output logic [15:0]                     out_checksum,
   output logic [15:0]                     drop_count,
   output logic [1:0]                      dbg_state
);
   localparam int W     = AXIS_BUS_WIDTH;
   localparam int KW    = W / 8;
   localparam int NW    = W / 16;
   localparam int IDW   = (AXIS_ID_WIDTH < 1) ? 1 : AXIS_ID_WIDTH;
   localparam int DESTW = (AXIS_DEST_WIDTH < 1) ? 1 : AXIS_DEST_WIDTH;
   localparam int AW    = $clog2(BUFFER_DEPTH);
   localparam int MW    = $clog2(META_DEPTH);
   localparam int DE_W  = W + KW + 1;
   localparam int MT_W  = 32 + IDW + DESTW;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCUM = 2'd1, S_DROP = 2'd2} state_t;

   state_t            state_q, state_d;
   logic [AW:0]       wr_spec_q, wr_spec_d, wr_cmt_q, wr_cmt_d, rd_q, rd_d;
   logic [MW:0]       mw_q, mw_d, mr_q, mr_d;
   logic [15:0]       len_q, len_d, csum_q, csum_d, drop_cnt_q, drop_cnt_d;
   logic [IDW-1:0]    id_q, id_d, id_cur;
   logic [DESTW-1:0]  dest_q, dest_d, dest_cur;
   logic              ready_en_q, ready_en_d;

   logic [DE_W-1:0]   dmem [BUFFER_DEPTH];
   logic [MT_W-1:0]   mmem [META_DEPTH];

   logic              data_full, meta_full, meta_empty, in_fire, out_fire, over;
   logic              data_we, meta_we;
   logic [15:0]       beat_len, len_next, csum_next;
   logic [DE_W-1:0]   rd_beat;
   logic [MT_W-1:0]   rd_meta;

   always_comb begin
      beat_len = '0;
      for (int i = 0; i < KW; i++) beat_len = beat_len + 16'(axis_in.tkeep[i]);
   end

   // Even packet offsets are the high byte of each 16-bit word; non-last beats are full, so beat lanes align to packet offsets.
   if (CALC_CHECKSUM != 0) begin : g_csum
      logic [31:0] raw;
      logic [16:0] fold1;
      logic [7:0]  hi, lo;
      always_comb begin
         raw = {16'd0, csum_q};
         hi  = '0;
         lo  = '0;
         for (int k = 0; k < NW; k++) begin
            hi  = axis_in.tkeep[2*k]   ? axis_in.tdata[16*k +: 8]   : 8'h00;
            lo  = axis_in.tkeep[2*k+1] ? axis_in.tdata[16*k+8 +: 8] : 8'h00;
            raw = raw + {16'd0, hi, lo};
         end
         fold1     = {1'b0, raw[15:0]} + {1'b0, raw[31:16]};
         csum_next = fold1[15:0] + {15'd0, fold1[16]};
      end
   end else begin : g_no_csum
      assign csum_next = '0;
   end

   assign data_full  = (wr_spec_q - rd_q) == (AW+1)'(BUFFER_DEPTH);
   assign meta_full  = (mw_q - mr_q) == (MW+1)'(META_DEPTH);
   assign meta_empty = (mw_q == mr_q);
   assign axis_in.tready = ready_en_q & ((state_q == S_DROP) | (~data_full & ~meta_full));
   assign in_fire    = axis_in.tvalid & axis_in.tready;
   assign len_next   = len_q + beat_len;
   assign over       = len_next > 16'(MAX_PACKET_LENGTH);
   assign id_cur     = (state_q == S_IDLE) ? axis_in.tid   : id_q;
   assign dest_cur   = (state_q == S_IDLE) ? axis_in.tdest : dest_q;

   always_comb begin
      state_d    = state_q;
      wr_spec_d  = wr_spec_q;
      wr_cmt_d   = wr_cmt_q;
      len_d      = len_q;
      csum_d     = csum_q;
      id_d       = id_q;
      dest_d     = dest_q;
      drop_cnt_d = drop_cnt_q;
      data_we    = 1'b0;
      meta_we    = 1'b0;
      if (in_fire) begin
         if (state_q == S_DROP) begin
            if (axis_in.tlast) state_d = S_IDLE;
         end else if (over) begin
            // Oversize: discard everything written for this packet by rewinding to the last commit.
            state_d    = axis_in.tlast ? S_IDLE : S_DROP;
            wr_spec_d  = wr_cmt_q;
            len_d      = '0;
            csum_d     = '0;
            drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
         end else begin
            data_we   = 1'b1;
            wr_spec_d = wr_spec_q + 1'b1;
            if (axis_in.tlast) begin
               state_d  = S_IDLE;
               wr_cmt_d = wr_spec_q + 1'b1;
               meta_we  = 1'b1;
               len_d    = '0;
               csum_d   = '0;
            end else begin
               state_d = S_ACCUM;
               len_d   = len_next;
               csum_d  = csum_next;
               id_d    = id_cur;
               dest_d  = dest_cur;
            end
         end
      end
   end

   assign rd_beat  = dmem[rd_q[AW-1:0]];
   assign rd_meta  = mmem[mr_q[MW-1:0]];
   assign out_fire = axis_out.tvalid & axis_out.tready;

   always_comb begin
      rd_d       = rd_q + {{AW{1'b0}}, out_fire};
      mr_d       = mr_q + {{MW{1'b0}}, out_fire & rd_beat[0]};
      mw_d       = mw_q + {{MW{1'b0}}, meta_we};
      ready_en_d = 1'b1;
   end

   assign axis_out.tvalid = ~meta_empty;
   assign axis_out.tdata  = rd_beat[DE_W-1 -: W];
   assign axis_out.tkeep  = rd_beat[KW:1];
   assign axis_out.tlast  = rd_beat[0];
   assign axis_out.tid    = rd_meta[DESTW +: IDW];
   assign axis_out.tdest  = rd_meta[DESTW-1:0];
   assign out_length      = axis_out.tvalid ? rd_meta[MT_W-1 -: 16] : 16'd0;
   assign out_checksum    = axis_out.tvalid ? rd_meta[MT_W-17 -: 16] : 16'd0;
   assign drop_count      = drop_cnt_q;
   assign dbg_state       = state_q;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= S_IDLE;
         wr_spec_q  <= '0;
         wr_cmt_q   <= '0;
         rd_q       <= '0;
         mw_q       <= '0;
         mr_q       <= '0;
         len_q      <= '0;
         csum_q     <= '0;
         id_q       <= '0;
         dest_q     <= '0;
         drop_cnt_q <= '0;
         ready_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_spec_q  <= wr_spec_d;
         wr_cmt_q   <= wr_cmt_d;
         rd_q       <= rd_d;
         mw_q       <= mw_d;
         mr_q       <= mr_d;
         len_q      <= len_d;
         csum_q     <= csum_d;
         id_q       <= id_d;
         dest_q     <= dest_d;
         drop_cnt_q <= drop_cnt_d;
         ready_en_q <= ready_en_d;
      end
   end

   always_ff @(posedge aclk) begin
      if (data_we) dmem[wr_spec_q[AW-1:0]] <= {axis_in.tdata, axis_in.tkeep, axis_in.tlast};
      if (meta_we) mmem[mw_q[MW-1:0]] <= {len_next, csum_next, id_cur, dest_cur};
   end
endmodule

// File: tb/tb_packet_len_csum_buffer.sv
// Bench for packet_len_csum_buffer: directed packets with an expected-beat queue checked by an output monitor.
module tb_packet_len_csum_buffer;
   localparam int W      = 64;
   localparam int KW     = W / 8;
   localparam int IDW    = 4;
   localparam int DESTW  = 4;
   localparam int EXP_W  = W + KW + 1 + IDW + DESTW + 32;
   localparam int TMO    = 4000;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [15:0] out_length, out_checksum, drop_count;
   logic [1:0]  dbg_state;

   packet_len_csum_buffer_if #(.DATA_W(W), .ID_W(IDW), .DEST_W(DESTW)) axis_in ();
   packet_len_csum_buffer_if #(.DATA_W(W), .ID_W(IDW), .DEST_W(DESTW)) axis_out ();

   packet_len_csum_buffer #(
      .AXIS_BUS_WIDTH(W), .AXIS_ID_WIDTH(IDW), .AXIS_DEST_WIDTH(DESTW),
      .MAX_PACKET_LENGTH(1522), .BUFFER_DEPTH(256), .META_DEPTH(8), .CALC_CHECKSUM(1)
   ) dut (
      .aclk(aclk), .aresetn(aresetn), .axis_in(axis_in), .axis_out(axis_out),
      .out_length(out_length), .out_checksum(out_checksum),
      .drop_count(drop_count), .dbg_state(dbg_state)
   );

   // clock / cycle counter
   always #5 aclk = ~aclk;
   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   logic [7:0]       pkt[$];
   logic [EXP_W-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   int out_mode = 0;
   int stall_cnt = 0;
   int last_acc_cyc = 0;
   int first_out_cyc = -1;
   bit out_first = 1'b1;

   function automatic logic [W-1:0] mask_data(input logic [W-1:0] d, input logic [KW-1:0] k);
      logic [W-1:0] r;
      r = '0;
      for (int j = 0; j < KW; j++) if (k[j]) r[8*j +: 8] = d[8*j +: 8];
      return r;
   endfunction

   function automatic logic [15:0] model_csum();
      logic [31:0] s;
      s = '0;
      for (int i = 0; i < pkt.size(); i++)
         s = s + ((i % 2 == 0) ? {16'd0, pkt[i], 8'd0} : {24'd0, pkt[i]});
      while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
      return s[15:0];
   endfunction

   task automatic report();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   endtask

   task automatic check_val(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fill_pkt(input int n, input logic [7:0] base);
      pkt.delete();
      for (int i = 0; i < n; i++) pkt.push_back(base + 8'(i));
   endtask

   task automatic push_expected(input logic [IDW-1:0] id, input logic [DESTW-1:0] dest,
                                input logic [15:0] elen, input logic [15:0] ecsum);
      int nb;
      logic [W-1:0] d;
      logic [KW-1:0] k;
      nb = (pkt.size() + KW - 1) / KW;
      for (int b = 0; b < nb; b++) begin
         d = '0;
         k = '0;
         for (int j = 0; j < KW; j++)
            if (b*KW + j < pkt.size()) begin d[8*j +: 8] = pkt[b*KW + j]; k[j] = 1'b1; end
         exp_q.push_back({d, k, (b == nb-1), id, dest, elen, ecsum});
      end
   endtask

   // driver: one beat per handshake, optional idle gaps
   task automatic send_pkt(input logic [IDW-1:0] id, input logic [DESTW-1:0] dest, input bit rnd);
      int nb, t;
      bit got;
      logic [W-1:0] d;
      logic [KW-1:0] k;
      nb = (pkt.size() + KW - 1) / KW;
      for (int b = 0; b < nb; b++) begin
         d = '0;
         k = '0;
         for (int j = 0; j < KW; j++)
            if (b*KW + j < pkt.size()) begin d[8*j +: 8] = pkt[b*KW + j]; k[j] = 1'b1; end
         if (rnd) repeat ($urandom_range(0, 2)) begin
            axis_in.tvalid = 1'b0;
            @(posedge aclk); #1;
         end
         axis_in.tvalid = 1'b1;
         axis_in.tdata  = d;
         axis_in.tkeep  = k;
         axis_in.tlast  = (b == nb-1);
         axis_in.tid    = id;
         axis_in.tdest  = dest;
         got = 1'b0;
         t = 0;
         while (!got && t < TMO) begin
            @(negedge aclk);
            if (axis_in.tready) got = 1'b1;
            else stall_cnt++;
            @(posedge aclk); #1;
            t++;
         end
         if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_accept_timeout: got no tready within %0d cycles", TMO);
            report();
         end
         last_acc_cyc = cyc;
      end
      axis_in.tvalid = 1'b0;
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 20000) begin
         @(posedge aclk); #1;
         t++;
      end
      repeat (2) @(posedge aclk);
      #1;
      check_val(name, exp_q.size(), 0);
   endtask

   initial begin
      axis_out.tready = 1'b0;
      forever begin
         @(posedge aclk); #1;
         case (out_mode)
            0:       axis_out.tready = 1'b1;
            1:       axis_out.tready = 1'b0;
            default: axis_out.tready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // scoreboard monitor
   initial begin : monitor
      logic [EXP_W-1:0] act, held, expv;
      bit held_v;
      held_v = 1'b0;
      forever begin
         @(negedge aclk);
         if (!aresetn) begin
            held_v = 1'b0;
            out_first = 1'b1;
         end else if (axis_out.tvalid) begin
            act = {mask_data(axis_out.tdata, axis_out.tkeep), axis_out.tkeep, axis_out.tlast,
                   axis_out.tid, axis_out.tdest, out_length, out_checksum};
            if (held_v) begin
               n_checks++;
               if (act !== held) begin
                  n_fail++;
                  $display("FAIL stall_stable: got %h expected %h", act, held);
               end
            end
            if (axis_out.tready) begin
               held_v = 1'b0;
               if (out_first) first_out_cyc = cyc;
               out_first = axis_out.tlast;
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL out_beat: got unexpected beat %h expected none", act);
               end else begin
                  expv = exp_q.pop_front();
                  if (act !== expv) begin
                     n_fail++;
                     $display("FAIL out_beat: got %h expected %h", act, expv);
                  end
               end
            end else begin
               held_v = 1'b1;
               held = act;
            end
         end else begin
            held_v = 1'b0;
         end
      end
   end

   initial begin : stim
      int tl;
      logic [7:0] b0;
      logic [IDW-1:0] rid;
      logic [DESTW-1:0] rdest;
      aresetn = 1'b0;
      axis_in.tvalid = 1'b0;
      axis_in.tdata  = '0;
      axis_in.tkeep  = '0;
      axis_in.tlast  = 1'b0;
      axis_in.tid    = '0;
      axis_in.tdest  = '0;

      @(negedge aclk);
      check_val("rst_in_tready", int'(axis_in.tready), 0);
      check_val("rst_out_tvalid", int'(axis_out.tvalid), 0);
      check_val("rst_out_length", int'(out_length), 0);
      check_val("rst_out_checksum", int'(out_checksum), 0);
      check_val("rst_drop_count", int'(drop_count), 0);
      repeat (2) @(posedge aclk);
      #1;
      aresetn = 1'b1;
      #1;
      check_val("tready_before_edge", int'(axis_in.tready), 0);
      @(posedge aclk); #1;
      check_val("tready_after_edge", int'(axis_in.tready), 1);

      // 64-byte packet, bytes 0..63, with first-beat latency
      fill_pkt(64, 8'h00);
      push_expected(4'h1, 4'h2, 16'd64, 16'hE403);
      send_pkt(4'h1, 4'h2, 1'b0);
      tl = last_acc_cyc;
      drain("drain_64");
      check_val("first_beat_latency", first_out_cyc - tl, 0);

      pkt.delete();
      pkt.push_back(8'h12); pkt.push_back(8'h34); pkt.push_back(8'h56);
      push_expected(4'h3, 4'h4, 16'd3, 16'h6834);
      send_pkt(4'h3, 4'h4, 1'b0);
      drain("drain_3");

      // oversize drop followed by a good packet
      fill_pkt(1600, 8'h11);
      stall_cnt = 0;
      send_pkt(4'h5, 4'h6, 1'b0);
      check_val("drop_no_stall", stall_cnt, 0);
      fill_pkt(60, 8'h80);
      push_expected(4'h7, 4'h8, 16'd60, model_csum());
      send_pkt(4'h7, 4'h8, 1'b0);
      drain("drain_60");
      check_val("drop_count_1", int'(drop_count), 1);

      // exactly max length passes, one byte more is dropped on its last beat
      fill_pkt(1522, 8'h05);
      push_expected(4'h9, 4'hA, 16'd1522, model_csum());
      send_pkt(4'h9, 4'hA, 1'b0);
      fill_pkt(1523, 8'h07);
      send_pkt(4'hB, 4'hC, 1'b0);
      drain("drain_max");
      check_val("drop_count_2", int'(drop_count), 2);

      // fill the descriptor queue with the output blocked
      out_mode = 1;
      repeat (3) @(posedge aclk);
      #1;
      for (int k = 0; k < 8; k++) begin
         b0 = 8'hA0 + 8'(k);
         pkt.delete();
         pkt.push_back(b0); pkt.push_back(8'(k));
         push_expected(IDW'(k), DESTW'(15 - k), 16'd2, {b0, 8'(k)});
         send_pkt(IDW'(k), DESTW'(15 - k), 1'b0);
      end
      @(negedge aclk);
      check_val("meta_full_tready", int'(axis_in.tready), 0);
      check_val("meta_full_tvalid", int'(axis_out.tvalid), 1);
      @(posedge aclk); #1;
      out_mode = 0;
      drain("drain_meta");

      // random handshakes on both sides
      out_mode = 2;
      for (int p = 0; p < 30; p++) begin
         pkt.delete();
         repeat ($urandom_range(1, 200)) pkt.push_back(8'($urandom_range(0, 255)));
         rid = IDW'($urandom_range(0, 15));
         rdest = DESTW'($urandom_range(0, 15));
         push_expected(rid, rdest, 16'(pkt.size()), model_csum());
         send_pkt(rid, rdest, 1'b1);
      end
      drain("drain_random");
      out_mode = 0;

      // reset with one buffered packet and one partial packet
      out_mode = 1;
      repeat (3) @(posedge aclk);
      #1;
      fill_pkt(16, 8'h30);
      send_pkt(4'h1, 4'h1, 1'b0);
      axis_in.tvalid = 1'b1;
      axis_in.tkeep  = '1;
      axis_in.tlast  = 1'b0;
      axis_in.tdata  = {$urandom, $urandom};
      repeat (3) @(posedge aclk);
      #1;
      aresetn = 1'b0;
      axis_in.tvalid = 1'b0;
      #1;
      check_val("midrst_in_tready", int'(axis_in.tready), 0);
      check_val("midrst_out_tvalid", int'(axis_out.tvalid), 0);
      check_val("midrst_out_length", int'(out_length), 0);
      check_val("midrst_out_checksum", int'(out_checksum), 0);
      check_val("midrst_drop_count", int'(drop_count), 0);
      repeat (2) @(posedge aclk);
      #1;
      aresetn = 1'b1;
      out_mode = 0;
      repeat (10) @(posedge aclk);
      #1;
      fill_pkt(24, 8'hC0);
      push_expected(4'hE, 4'hD, 16'd24, model_csum());
      send_pkt(4'hE, 4'hD, 1'b0);
      drain("drain_after_reset");

      report();
   end
endmodule
